// File: rtl/distribuidor_papeis.sv
// Role dealer for the werewolf game: LFSR-driven Fisher-Yates shuffle over N_JOGADORES seats.
// Optional macro VIDENTE_EN adds one vidente (2'b10) role to the deal.
module distribuidor_papeis #(
  parameter int unsigned N_JOGADORES = 8,
  parameter int unsigned N_LOBOS     = 2,
  parameter logic [15:0] SEED_PADRAO = 16'hACE1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           e_seed_reg,
  input  logic [15:0]                    seed,
  input  logic                           zera_CS,
  input  logic                           inicia,
  input  logic [$clog2(N_JOGADORES)-1:0] idx_consulta,
  output logic [1:0]                     papel_consulta,
  output logic                           ocupado,
  output logic                           pronto,
  output logic [2:0]                     db_estado
);

  localparam int unsigned W = $clog2(N_JOGADORES);
`ifdef VIDENTE_EN
  localparam bit VID_EN = 1'b1;
`else
  localparam bit VID_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    INICIALIZA = 3'd1,
    SORTEIA    = 3'd2,
    TROCA      = 3'd3,
    FIM        = 3'd4
  } estado_t;

  estado_t      estado;
  logic [15:0]  lfsr;
  logic [W-1:0] i;
  logic [W-1:0] j;
  logic [W-1:0] cand;
  logic [1:0]   seats [N_JOGADORES];

  // Galois right-shift step, taps 16'hB400
  function automatic logic [15:0] lfsr_passo(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  assign cand      = lfsr[W-1:0];
  assign db_estado = estado;

  // Control FSM, LFSR and seat array
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      lfsr    <= SEED_PADRAO;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      i       <= W'(N_JOGADORES - 1);
      j       <= '0;
      for (int unsigned k = 0; k < N_JOGADORES; k++) seats[k] <= 2'b00;
    end else if (zera_CS) begin
      // Abort keeps the LFSR so the game sequence stays reproducible
      estado  <= OCIOSO;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      i       <= W'(N_JOGADORES - 1);
      for (int unsigned k = 0; k < N_JOGADORES; k++) seats[k] <= 2'b00;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (e_seed_reg) lfsr <= (seed == 16'h0000) ? SEED_PADRAO : seed;
          if (inicia) begin
            estado  <= INICIALIZA;
            ocupado <= 1'b1;
            pronto  <= 1'b0;
          end
        end
        INICIALIZA: begin
          for (int unsigned k = 0; k < N_JOGADORES; k++) begin
            if (k < N_LOBOS)                seats[k] <= 2'b01;
            else if (VID_EN && k == N_LOBOS) seats[k] <= 2'b10;
            else                            seats[k] <= 2'b00;
          end
          i      <= W'(N_JOGADORES - 1);
          estado <= SORTEIA;
        end
        SORTEIA: begin
          // Rejection sampling keeps the draw uniform without a modulo
          lfsr <= lfsr_passo(lfsr);
          if (cand <= i) begin
            j      <= cand;
            estado <= TROCA;
          end
        end
        TROCA: begin
          seats[i] <= seats[j];
          seats[j] <= seats[i];
          if (i == W'(1)) begin
            estado  <= FIM;
            ocupado <= 1'b0;
            pronto  <= 1'b1;
          end else begin
            i      <= i - W'(1);
            estado <= SORTEIA;
          end
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
          pronto  <= 1'b0;
        end
      endcase
    end
  end

  // Read-back port; indices beyond the last seat read as aldeao
  always_comb begin
    papel_consulta = 2'b00;
    for (int unsigned k = 0; k < N_JOGADORES; k++) begin
      if (idx_consulta == W'(k)) papel_consulta = seats[k];
    end
  end

endmodule

// File: tb/tb_distribuidor_papeis.sv
// Scoreboard bench for distribuidor_papeis: 8-seat/2-wolf instance plus a 5-seat/1-wolf instance.
module tb_distribuidor_papeis;

`ifdef VIDENTE_EN
  localparam int VID = 1;
`else
  localparam int VID = 0;
`endif

  logic        clock;
  logic        reset;
  logic        e_seed_reg, zera_CS, inicia;
  logic [15:0] seed;
  logic [2:0]  idx;
  logic [1:0]  papel;
  logic        ocupado, pronto;
  logic [2:0]  estado;

  logic        e_seed_reg2, zera_CS2, inicia2;
  logic [15:0] seed2;
  logic [2:0]  idx2;
  logic [1:0]  papel2;
  logic        ocupado2, pronto2;
  logic [2:0]  estado2;

  int vectors;
  int miscompares;

  logic [1:0]  exp_q [$];
  int          lat_q [$];
  logic [15:0] m_lfsr, m_lfsr2;
  logic [1:0]  last_seats [16];

  distribuidor_papeis dut (
    .clock(clock), .reset(reset), .e_seed_reg(e_seed_reg), .seed(seed),
    .zera_CS(zera_CS), .inicia(inicia), .idx_consulta(idx),
    .papel_consulta(papel), .ocupado(ocupado), .pronto(pronto), .db_estado(estado)
  );

  distribuidor_papeis #(.N_JOGADORES(5), .N_LOBOS(1)) dut2 (
    .clock(clock), .reset(reset), .e_seed_reg(e_seed_reg2), .seed(seed2),
    .zera_CS(zera_CS2), .inicia(inicia2), .idx_consulta(idx2),
    .papel_consulta(papel2), .ocupado(ocupado2), .pronto(pronto2), .db_estado(estado2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] passo(input logic [15:0] l);
    logic b;
    b = l[0];
    l = l >> 1;
    if (b) l = l ^ 16'hB400;
    return l;
  endfunction

  // Reference deal: pushes expected seats and expected latency
  task automatic model_deal(input int n, input int l, input logic [15:0] lf_in,
                            output logic [15:0] lf_out);
    logic [1:0]  s [16];
    logic [1:0]  t;
    logic [15:0] lf;
    int mask, lat, jj, guard;
    lf = lf_in;
    mask = 1;
    while (mask < n) mask = mask << 1;
    mask = mask - 1;
    for (int k = 0; k < 16; k++) s[k] = 2'b00;
    for (int k = 0; k < n; k++) begin
      if (k < l) s[k] = 2'b01;
      else if (VID == 1 && k == l) s[k] = 2'b10;
    end
    lat = 1;
    for (int i = n - 1; i >= 1; i--) begin
      guard = 0;
      do begin
        lat++;
        jj = int'(lf[3:0]) & mask;
        lf = passo(lf);
        guard++;
      end while (jj > i && guard < 10000);
      lat++;
      t = s[i]; s[i] = s[jj]; s[jj] = t;
    end
    for (int k = 0; k < n; k++) exp_q.push_back(s[k]);
    lat_q.push_back(lat);
    lf_out = lf;
  endtask

  task automatic load_seed(input bit sel, input logic [15:0] v);
    if (sel) begin e_seed_reg2 = 1'b1; seed2 = v; end
    else begin e_seed_reg = 1'b1; seed = v; end
    @(posedge clock); #1;
    e_seed_reg = 1'b0; e_seed_reg2 = 1'b0;
    if (sel) m_lfsr2 = (v == 16'h0) ? 16'hACE1 : v;
    else     m_lfsr  = (v == 16'h0) ? 16'hACE1 : v;
  endtask

  // Starts a deal, waits for pronto, scores latency, seats and role counts
  task automatic run_deal(input bit sel, input bit load, input logic [15:0] sv, input bit spurious);
    int n, l, c, exp_lat, nl, nv, na;
    bit done;
    logic [15:0] lf;
    logic [1:0] got, expv;
    n = sel ? 5 : 8;
    l = sel ? 1 : 2;
    lf = sel ? m_lfsr2 : m_lfsr;
    if (load) lf = (sv == 16'h0) ? 16'hACE1 : sv;
    model_deal(n, l, lf, lf);
    if (sel) m_lfsr2 = lf; else m_lfsr = lf;
    if (sel) begin
      inicia2 = 1'b1;
      if (load) begin e_seed_reg2 = 1'b1; seed2 = sv; end
    end else begin
      inicia = 1'b1;
      if (load) begin e_seed_reg = 1'b1; seed = sv; end
    end
    c = 0;
    done = 1'b0;
    while (!done && c < 400) begin
      @(posedge clock); #1;
      c++;
      if (c == 1) begin
        inicia = 1'b0; inicia2 = 1'b0; e_seed_reg = 1'b0; e_seed_reg2 = 1'b0;
        vectors++;
        if ((sel ? ocupado2 : ocupado) !== 1'b1) begin
          miscompares++;
          $display("FAIL ocupado_rise got=%b exp=1", sel ? ocupado2 : ocupado);
        end
      end
      if (spurious && c == 3) begin e_seed_reg = 1'b1; seed = 16'h1234; end
      if (spurious && c == 4) e_seed_reg = 1'b0;
      done = sel ? pronto2 : pronto;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL deal_timeout got=no_pronto exp=pronto within %0d cycles", c);
      repeat (n) void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      return;
    end
    exp_lat = lat_q.pop_front();
    vectors++;
    if (c - 1 !== exp_lat || c - 1 < 2 * n - 1) begin
      miscompares++;
      $display("FAIL latency got=%0d exp=%0d (min %0d)", c - 1, exp_lat, 2 * n - 1);
    end
    nl = 0; nv = 0; na = 0;
    for (int k = 0; k < n; k++) begin
      if (sel) idx2 = 3'(k); else idx = 3'(k);
      #1;
      got = sel ? papel2 : papel;
      expv = exp_q.pop_front();
      last_seats[k] = got;
      vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("FAIL seat[%0d] dut%0d got=%b exp=%b", k, sel ? 2 : 1, got, expv);
      end
      if (got == 2'b01) nl++;
      else if (got == 2'b10) nv++;
      else if (got == 2'b00) na++;
    end
    vectors++;
    if (nl != l || nv != VID || na != n - l - VID) begin
      miscompares++;
      $display("FAIL role_counts got=lobos:%0d vid:%0d ald:%0d exp=%0d/%0d/%0d",
               nl, nv, na, l, VID, n - l - VID);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    e_seed_reg = 0; zera_CS = 0; inicia = 0; seed = 0; idx = 0;
    e_seed_reg2 = 0; zera_CS2 = 0; inicia2 = 0; seed2 = 0; idx2 = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    m_lfsr2 = 16'hACE1;
    vectors++;
    if (pronto !== 1'b0 || ocupado !== 1'b0 || estado !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_flags got=p%b o%b e%0d exp=p0 o0 e0", pronto, ocupado, estado);
    end
    vectors++;
    if (pronto2 !== 1'b0 || ocupado2 !== 1'b0 || estado2 !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_flags2 got=p%b o%b e%0d exp=p0 o0 e0", pronto2, ocupado2, estado2);
    end
    for (int k = 0; k < 8; k++) begin
      idx = 3'(k);
      #1;
      vectors++;
      if (papel !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_seat[%0d] got=%b exp=00", k, papel);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_normal_deal();
    load_seed(1'b0, 16'h0001);
    run_deal(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_determinism();
    logic [1:0] a [16];
    load_seed(1'b0, 16'h0000);
    run_deal(1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) a[k] = last_seats[k];
    zera_CS = 1'b1;
    @(posedge clock); #1;
    zera_CS = 1'b0;
    load_seed(1'b0, 16'hACE1);
    run_deal(1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (last_seats[k] !== a[k]) begin
        miscompares++;
        $display("FAIL determinism seat[%0d] got=%b exp=%b", k, last_seats[k], a[k]);
      end
    end
  endtask

  task automatic test_abort();
    int c;
    load_seed(1'b0, 16'h0001);
    inicia = 1'b1;
    @(posedge clock); #1;
    inicia = 1'b0;
    c = 0;
    while (estado !== 3'd2 && c < 20) begin
      @(posedge clock); #1;
      c++;
    end
    vectors++;
    if (estado !== 3'd2) begin
      miscompares++;
      $display("FAIL abort_reach_sorteia got=%0d exp=2", estado);
    end
    zera_CS = 1'b1;
    @(posedge clock); #1;
    zera_CS = 1'b0;
    vectors++;
    if (estado !== 3'd0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_flags got=e%0d o%b p%b exp=e0 o0 p0", estado, ocupado, pronto);
    end
    for (int k = 0; k < 8; k++) begin
      idx = 3'(k);
      #1;
      vectors++;
      if (papel !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_seat[%0d] got=%b exp=00", k, papel);
      end
    end
    @(posedge clock); #1;
    run_deal(1'b0, 1'b1, 16'h5A5A, 1'b0);
  endtask

  task automatic test_priority();
    zera_CS = 1'b1; inicia = 1'b1; e_seed_reg = 1'b1; seed = 16'h7777;
    @(posedge clock); #1;
    zera_CS = 1'b0; inicia = 1'b0; e_seed_reg = 1'b0;
    vectors++;
    if (estado !== 3'd0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL zera_priority got=e%0d o%b p%b exp=e0 o0 p0", estado, ocupado, pronto);
    end
    run_deal(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_seed_ignored();
    run_deal(1'b0, 1'b1, 16'hBEEF, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_deal(1'b0, 1'b0, 16'h0, 1'b0);
    run_deal(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_sweep();
    load_seed(1'b1, 16'h0001);
    run_deal(1'b1, 1'b0, 16'h0, 1'b0);
    for (int k = 5; k < 8; k++) begin
      idx2 = 3'(k);
      #1;
      vectors++;
      if (papel2 !== 2'b00) begin
        miscompares++;
        $display("FAIL sweep_out_of_range idx=%0d got=%b exp=00", k, papel2);
      end
    end
    run_deal(1'b1, 1'b1, 16'h00FF, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_normal_deal();
    test_determinism();
    test_abort();
    test_priority();
    test_seed_ignored();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
